// File: rtl/mcpu_core_pkg.sv
// Shared writeback-stage types and sizes for the 4-lane core.
package mcpu_core_pkg;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int NUM_LANES = 4;
  localparam int NUM_REGS  = 1 << REG_W;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ld_ret_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/mcpu_core_wb_stage_if.sv
// Execute, decode, memory-return and register-file signals of the writeback stage.
interface mcpu_core_wb_stage_if;
  import mcpu_core_pkg::*;

  logic [REG_W-1:0]    ex2wb_rd_num   [NUM_LANES];
  logic [DATA_W-1:0]   ex2wb_rd_data  [NUM_LANES];
  logic                ex2wb_rd_we    [NUM_LANES];
  logic                ex2wb_pred_we  [NUM_LANES];
  logic                d2wb_ld_issue;
  logic [REG_W-1:0]    d2wb_ld_rd;
  logic                mem2wb_valid;
  logic [REG_W-1:0]    mem2wb_rd;
  logic [DATA_W-1:0]   mem2wb_data;
  logic                mem2wb_ready;
  logic [REG_W-1:0]    wb2rf_rd_num   [NUM_LANES];
  logic [DATA_W-1:0]   wb2rf_rd_data  [NUM_LANES];
  logic                wb2rf_rd_we    [NUM_LANES];
  logic                wb2rf_pred_we  [NUM_LANES];
  logic [NUM_REGS-1:0] wb2d_busy;

  modport master (
    output ex2wb_rd_num, ex2wb_rd_data, ex2wb_rd_we, ex2wb_pred_we,
    output d2wb_ld_issue, d2wb_ld_rd,
    output mem2wb_valid, mem2wb_rd, mem2wb_data,
    input  mem2wb_ready,
    input  wb2rf_rd_num, wb2rf_rd_data, wb2rf_rd_we, wb2rf_pred_we,
    input  wb2d_busy
  );

  modport slave (
    input  ex2wb_rd_num, ex2wb_rd_data, ex2wb_rd_we, ex2wb_pred_we,
    input  d2wb_ld_issue, d2wb_ld_rd,
    input  mem2wb_valid, mem2wb_rd, mem2wb_data,
    output mem2wb_ready,
    output wb2rf_rd_num, wb2rf_rd_data, wb2rf_rd_we, wb2rf_pred_we,
    output wb2d_busy
  );
endinterface

// File: rtl/mcpu_core_wb_skid.sv
// Circular load-return skid buffer; pops up to two entries per cycle from the head.
module mcpu_core_wb_skid
  import mcpu_core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst,
  input  logic             push_i,
  input  ld_ret_t          push_data_i,
  input  logic             pop0_i,
  input  logic             pop1_i,
  output ld_ret_t          head0_o,
  output ld_ret_t          head1_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ld_ret_t          mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       pop_n;

  always_comb begin
    pop_n    = pop1_i ? 2'd2 : (pop0_i ? 2'd1 : 2'd0);
    head_nxt = head_q + PTR_W'(1);
    head_d   = head_q + PTR_W'(pop_n);
    tail_d   = tail_q + PTR_W'(push_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_n);
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is data-only; validity is carried entirely by count_q.
  always_ff @(posedge clkrst_core_clk) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  assign head0_o = mem_q[head_q];
  assign head1_o = mem_q[head_nxt];
  assign count_o = count_q;
endmodule

// File: rtl/mcpu_core_wb_stage.sv
// Writeback stage: registers lane results, merges load returns into free lanes, tracks busy loads.
// Optional counters stat_* are built when MCPU_CORE_WB_STATS_EN is defined.
module mcpu_core_wb_stage
  import mcpu_core_pkg::*;
#(
  parameter int SKID_DEPTH = 2
) (
  input  logic                 clkrst_core_clk,
  input  logic                 clkrst_core_rst,
  mcpu_core_wb_stage_if.slave  wb
`ifdef MCPU_CORE_WB_STATS_EN
  ,
  output logic [31:0]          stat_merged,
  output logic [31:0]          stat_buffered,
  output logic [31:0]          stat_full_cycles,
  output logic [31:0]          stat_orphan_ret
`endif
);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic [CNT_W-1:0]    count;
  ld_ret_t             head0, head1, inc, cand0, cand1;
  logic                ready, accept, push, pop0, pop1, inc_merged;
  logic [1:0]          nfree, nbuf, nav, nmerge, f0, f1;
  logic [NUM_REGS-1:0] busy_q, busy_d, clr, set;

  logic [REG_W-1:0]    num_q  [NUM_LANES];
  logic [REG_W-1:0]    num_d  [NUM_LANES];
  logic [DATA_W-1:0]   data_q [NUM_LANES];
  logic [DATA_W-1:0]   data_d [NUM_LANES];
  logic                we_q   [NUM_LANES];
  logic                we_d   [NUM_LANES];
  logic                pwe_q  [NUM_LANES];
  logic                pwe_d  [NUM_LANES];

  mcpu_core_wb_skid #(.DEPTH(SKID_DEPTH), .CNT_W(CNT_W)) u_skid (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .push_i          (push),
    .push_data_i     (inc),
    .pop0_i          (pop0),
    .pop1_i          (pop1),
    .head0_o         (head0),
    .head1_o         (head1),
    .count_o         (count)
  );

  assign ready   = (count < CNT_W'(SKID_DEPTH));
  assign accept  = wb.mem2wb_valid && ready;
  assign inc.rd  = wb.mem2wb_rd;
  assign inc.data = wb.mem2wb_data;

  always_comb begin
    nfree = 2'd0;
    f0    = 2'd0;
    f1    = 2'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!wb.ex2wb_rd_we[k] && !wb.ex2wb_pred_we[k]) begin
        if (nfree == 2'd0)      f0 = 2'(k);
        else if (nfree == 2'd1) f1 = 2'(k);
        if (nfree != 2'd2) nfree = nfree + 2'd1;
      end
    end

    // Only the two oldest candidates can ever be merged in one cycle.
    nbuf  = (count >= CNT_W'(2)) ? 2'd2 : 2'(count);
    cand0 = inc;
    cand1 = inc;
    if (nbuf == 2'd1) cand0 = head0;
    if (nbuf == 2'd2) begin
      cand0 = head0;
      cand1 = head1;
    end
    nav        = (nbuf == 2'd2) ? 2'd2 : nbuf + {1'b0, accept};
    nmerge     = (nfree < nav) ? nfree : nav;
    pop0       = (nmerge != 2'd0) && (nbuf != 2'd0);
    pop1       = (nmerge == 2'd2) && (nbuf == 2'd2);
    inc_merged = accept && (nmerge > nbuf);
    push       = accept && !inc_merged;

    clr = '0;
    set = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      num_d[k]  = wb.ex2wb_rd_num[k];
      data_d[k] = wb.ex2wb_rd_data[k];
      we_d[k]   = wb.ex2wb_rd_we[k];
      pwe_d[k]  = wb.ex2wb_pred_we[k];
    end
    if (nmerge != 2'd0) begin
      num_d[f0]  = cand0.rd;
      data_d[f0] = cand0.data;
      we_d[f0]   = 1'b1;
      pwe_d[f0]  = 1'b0;
      clr[cand0.rd] = 1'b1;
    end
    if (nmerge == 2'd2) begin
      num_d[f1]  = cand1.rd;
      data_d[f1] = cand1.data;
      we_d[f1]   = 1'b1;
      pwe_d[f1]  = 1'b0;
      clr[cand1.rd] = 1'b1;
    end
    if (wb.d2wb_ld_issue) set[wb.d2wb_ld_rd] = 1'b1;
    busy_d = (busy_q & ~clr) | set;
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      busy_q <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        num_q[k]  <= '0;
        data_q[k] <= '0;
        we_q[k]   <= 1'b0;
        pwe_q[k]  <= 1'b0;
      end
    end else begin
      busy_q <= busy_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        num_q[k]  <= num_d[k];
        data_q[k] <= data_d[k];
        we_q[k]   <= we_d[k];
        pwe_q[k]  <= pwe_d[k];
      end
    end
  end

  assign wb.mem2wb_ready  = ready;
  assign wb.wb2d_busy     = busy_q;
  assign wb.wb2rf_rd_num  = num_q;
  assign wb.wb2rf_rd_data = data_q;
  assign wb.wb2rf_rd_we   = we_q;
  assign wb.wb2rf_pred_we = pwe_q;

`ifdef MCPU_CORE_WB_STATS_EN
  logic [31:0] merged_q, buffered_q, full_q, orphan_q;

  // Orphan is judged at acceptance against the scoreboard as it stood that cycle.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      merged_q   <= '0;
      buffered_q <= '0;
      full_q     <= '0;
      orphan_q   <= '0;
    end else begin
      merged_q   <= sat_add32(merged_q, nmerge);
      buffered_q <= sat_add32(buffered_q, {1'b0, push});
      full_q     <= sat_add32(full_q, {1'b0, !ready});
      orphan_q   <= sat_add32(orphan_q, {1'b0, accept && !busy_q[inc.rd]});
    end
  end

  assign stat_merged      = merged_q;
  assign stat_buffered    = buffered_q;
  assign stat_full_cycles = full_q;
  assign stat_orphan_ret  = orphan_q;
`endif
endmodule

// File: tb/tb_mcpu_core_wb_stage.sv
// Directed bench for the writeback stage: lane pass-through, load merge, skid, scoreboard, reset.
module tb_mcpu_core_wb_stage;
  import mcpu_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mcpu_core_wb_stage_if wbif ();

`ifdef MCPU_CORE_WB_STATS_EN
  logic [31:0] st_merged, st_buffered, st_full, st_orphan;
`endif

  mcpu_core_wb_stage #(.SKID_DEPTH(2)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .wb              (wbif)
`ifdef MCPU_CORE_WB_STATS_EN
    ,
    .stat_merged      (st_merged),
    .stat_buffered    (st_buffered),
    .stat_full_cycles (st_full),
    .stat_orphan_ret  (st_orphan)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic we, input logic pwe,
                          input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    wbif.ex2wb_rd_we[k]   = we;
    wbif.ex2wb_pred_we[k] = pwe;
    wbif.ex2wb_rd_num[k]  = rd;
    wbif.ex2wb_rd_data[k] = d;
  endtask

  task automatic free_lanes();
    for (int k = 0; k < NUM_LANES; k++) set_lane(k, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic busy_lanes();
    for (int k = 0; k < NUM_LANES; k++) set_lane(k, 1'b1, 1'b0, REG_W'(10 + k), DATA_W'(32'h100 + k));
  endtask

  task automatic mem(input logic v, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    wbif.mem2wb_valid = v;
    wbif.mem2wb_rd    = rd;
    wbif.mem2wb_data  = d;
  endtask

  task automatic issue(input logic v, input logic [REG_W-1:0] rd);
    wbif.d2wb_ld_issue = v;
    wbif.d2wb_ld_rd    = rd;
  endtask

  task automatic check_no_writes(input string tag);
    for (int k = 0; k < NUM_LANES; k++) begin
      check($sformatf("%s_we%0d", tag, k), 64'(wbif.wb2rf_rd_we[k]), 64'd0);
      check($sformatf("%s_pwe%0d", tag, k), 64'(wbif.wb2rf_pred_we[k]), 64'd0);
    end
  endtask

  initial begin
    free_lanes();
    mem(1'b0, '0, '0);
    issue(1'b0, '0);
    tick();
    tick();
    check_no_writes("rst");
    check("rst_busy", 64'(wbif.wb2d_busy), 64'd0);
    check("rst_ready", 64'(wbif.mem2wb_ready), 64'd1);
    rst = 1'b0;

    // Lane pass-through, one cycle latency
    set_lane(2, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF);
    tick();
    check("pt_we2", 64'(wbif.wb2rf_rd_we[2]), 64'd1);
    check("pt_num2", 64'(wbif.wb2rf_rd_num[2]), 64'd7);
    check("pt_data2", 64'(wbif.wb2rf_rd_data[2]), 64'hDEADBEEF);
    check("pt_we0", 64'(wbif.wb2rf_rd_we[0]), 64'd0);
    check("pt_we1", 64'(wbif.wb2rf_rd_we[1]), 64'd0);
    check("pt_we3", 64'(wbif.wb2rf_rd_we[3]), 64'd0);
    free_lanes();

    // Predicate-only lane passes through, occupies the slot
    set_lane(0, 1'b0, 1'b1, 5'd0, 32'h0);
    tick();
    check("pred_pwe0", 64'(wbif.wb2rf_pred_we[0]), 64'd1);
    check("pred_we0", 64'(wbif.wb2rf_rd_we[0]), 64'd0);
    free_lanes();

    // Load to r5, return merges into lane 2
    issue(1'b1, 5'd5);
    tick();
    check("iss5_busy", 64'(wbif.wb2d_busy), 64'h20);
    issue(1'b0, '0);
    set_lane(0, 1'b1, 1'b0, 5'd1, 32'h11);
    set_lane(1, 1'b1, 1'b0, 5'd2, 32'h22);
    mem(1'b1, 5'd5, 32'h1234);
    tick();
    check("m5_we0", 64'(wbif.wb2rf_rd_we[0]), 64'd1);
    check("m5_num0", 64'(wbif.wb2rf_rd_num[0]), 64'd1);
    check("m5_we2", 64'(wbif.wb2rf_rd_we[2]), 64'd1);
    check("m5_pwe2", 64'(wbif.wb2rf_pred_we[2]), 64'd0);
    check("m5_num2", 64'(wbif.wb2rf_rd_num[2]), 64'd5);
    check("m5_data2", 64'(wbif.wb2rf_rd_data[2]), 64'h1234);
    check("m5_we3", 64'(wbif.wb2rf_rd_we[3]), 64'd0);
    check("m5_busy", 64'(wbif.wb2d_busy), 64'd0);
    mem(1'b0, '0, '0);
    free_lanes();

    // Skid: fill with lanes busy, then drain two in one cycle
    for (int r = 20; r < 23; r++) begin
      issue(1'b1, REG_W'(r));
      tick();
    end
    issue(1'b0, '0);
    check("sk_busy0", 64'(wbif.wb2d_busy), 64'h0070_0000);
    busy_lanes();
    mem(1'b1, 5'd20, 32'hA0);
    tick();
    check("sk_ready1", 64'(wbif.mem2wb_ready), 64'd1);
    check("sk_num0", 64'(wbif.wb2rf_rd_num[0]), 64'd10);
    mem(1'b1, 5'd21, 32'hA1);
    tick();
    check("sk_ready2", 64'(wbif.mem2wb_ready), 64'd0);
    mem(1'b1, 5'd22, 32'hA2);
    tick();
    check("sk_ready3", 64'(wbif.mem2wb_ready), 64'd0);
    check("sk_busy3", 64'(wbif.wb2d_busy), 64'h0070_0000);
    check("sk_num3", 64'(wbif.wb2rf_rd_num[3]), 64'd13);
    free_lanes();
    tick();
    check("dr_num0", 64'(wbif.wb2rf_rd_num[0]), 64'd20);
    check("dr_data0", 64'(wbif.wb2rf_rd_data[0]), 64'hA0);
    check("dr_we0", 64'(wbif.wb2rf_rd_we[0]), 64'd1);
    check("dr_num1", 64'(wbif.wb2rf_rd_num[1]), 64'd21);
    check("dr_data1", 64'(wbif.wb2rf_rd_data[1]), 64'hA1);
    check("dr_we2", 64'(wbif.wb2rf_rd_we[2]), 64'd0);
    check("dr_ready", 64'(wbif.mem2wb_ready), 64'd1);
    check("dr_busy", 64'(wbif.wb2d_busy), 64'h0040_0000);
    tick();
    check("by_num0", 64'(wbif.wb2rf_rd_num[0]), 64'd22);
    check("by_data0", 64'(wbif.wb2rf_rd_data[0]), 64'hA2);
    check("by_we1", 64'(wbif.wb2rf_rd_we[1]), 64'd0);
    check("by_busy", 64'(wbif.wb2d_busy), 64'd0);
    mem(1'b0, '0, '0);
    tick();
    check_no_writes("idle");

    // Simultaneous set and clear of r9: set wins
    issue(1'b1, 5'd9);
    tick();
    mem(1'b1, 5'd9, 32'h99);
    tick();
    check("sc_num0", 64'(wbif.wb2rf_rd_num[0]), 64'd9);
    check("sc_we0", 64'(wbif.wb2rf_rd_we[0]), 64'd1);
    check("sc_busy", 64'(wbif.wb2d_busy), 64'h200);
    issue(1'b0, '0);
    tick();
    check("sc_clear", 64'(wbif.wb2d_busy), 64'd0);
    mem(1'b0, '0, '0);

    // Reset with two buffered entries
    issue(1'b1, 5'd24);
    tick();
    issue(1'b1, 5'd25);
    tick();
    issue(1'b0, '0);
    busy_lanes();
    mem(1'b1, 5'd24, 32'hB4);
    tick();
    mem(1'b1, 5'd25, 32'hB5);
    tick();
    mem(1'b0, '0, '0);
    check("pr_ready", 64'(wbif.mem2wb_ready), 64'd0);
    check("pr_busy", 64'(wbif.wb2d_busy), 64'h0300_0000);
    free_lanes();
    rst = 1'b1;
    #1;
    check("ar_busy", 64'(wbif.wb2d_busy), 64'd0);
    check("ar_ready", 64'(wbif.mem2wb_ready), 64'd1);
    check_no_writes("ar");
    tick();
    rst = 1'b0;
    tick();
    check_no_writes("post1");
    tick();
    check_no_writes("post2");
    check("post_busy", 64'(wbif.wb2d_busy), 64'd0);

`ifdef MCPU_CORE_WB_STATS_EN
    mem(1'b1, 5'd3, 32'h33);
    tick();
    mem(1'b0, '0, '0);
    check("st_num0", 64'(wbif.wb2rf_rd_num[0]), 64'd3);
    check("st_we0", 64'(wbif.wb2rf_rd_we[0]), 64'd1);
    check("st_orphan", 64'(st_orphan), 64'd1);
    check("st_merged", 64'(st_merged), 64'd1);
    check("st_buffered", 64'(st_buffered), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
